// File: rtl/id_ex_stage_reg_pkg.sv
// Shared widths, NOP encodings and slot actions for the ID->EX stage register.
// Build with IDEX_SKID_EN defined to get the 2-entry (main + skid) variant.
package id_ex_stage_reg_pkg;

    localparam int AluOpBus   = 8;
    localparam int AluSelBus  = 3;
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [AluOpBus-1:0]   EXE_NOP_OP   = 8'h00;
    localparam logic [AluSelBus-1:0]  EXE_RES_NOP  = 3'b000;
    localparam logic [RegBus-1:0]     ZeroWord     = 32'h0000_0000;
    localparam logic [RegAddrBus-1:0] NOPRegAddr   = 5'b00000;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic                  WriteEnable  = 1'b1;

    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_CLEAR = 2'd2
    } slot_act_e;

endpackage

// File: rtl/id_ex_payload_slot.sv
// One valid bit plus decoded payload; LOAD captures new values,
// CLEAR empties the slot and parks the payload at NOP values.
module id_ex_payload_slot
    import id_ex_stage_reg_pkg::*;
#(
    parameter int ALUOP_W  = AluOpBus,
    parameter int ALUSEL_W = AluSelBus,
    parameter int REG_W    = RegBus,
    parameter int RADDR_W  = RegAddrBus
) (
    input  logic                clk,
    input  logic                rst,
    input  slot_act_e           act,
    input  logic [ALUOP_W-1:0]  new_aluop,
    input  logic [ALUSEL_W-1:0] new_alusel,
    input  logic [REG_W-1:0]    new_reg1,
    input  logic [REG_W-1:0]    new_reg2,
    input  logic [RADDR_W-1:0]  new_wd,
    input  logic                new_wreg,
    output logic                valid,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [ALUSEL_W-1:0] alusel,
    output logic [REG_W-1:0]    reg1,
    output logic [REG_W-1:0]    reg2,
    output logic [RADDR_W-1:0]  wd,
    output logic                wreg
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= 1'b0;
            aluop  <= ALUOP_W'(EXE_NOP_OP);
            alusel <= ALUSEL_W'(EXE_RES_NOP);
            reg1   <= REG_W'(ZeroWord);
            reg2   <= REG_W'(ZeroWord);
            wd     <= RADDR_W'(NOPRegAddr);
            wreg   <= WriteDisable;
        end else begin
            unique case (act)
                SLOT_LOAD: begin
                    valid  <= 1'b1;
                    aluop  <= new_aluop;
                    alusel <= new_alusel;
                    reg1   <= new_reg1;
                    reg2   <= new_reg2;
                    wd     <= new_wd;
                    wreg   <= new_wreg;
                end
                SLOT_CLEAR: begin
                    valid  <= 1'b0;
                    aluop  <= ALUOP_W'(EXE_NOP_OP);
                    alusel <= ALUSEL_W'(EXE_RES_NOP);
                    reg1   <= REG_W'(ZeroWord);
                    reg2   <= REG_W'(ZeroWord);
                    wd     <= RADDR_W'(NOPRegAddr);
                    wreg   <= WriteDisable;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EX stage register with valid/ready handshake, flush and bubble counter.
// IDEX_SKID_EN adds a skid slot so id_ready comes straight from a flop.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int ALUOP_W  = AluOpBus,
    parameter int ALUSEL_W = AluSelBus,
    parameter int REG_W    = RegBus,
    parameter int RADDR_W  = RegAddrBus,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [REG_W-1:0]    id_reg1,
    input  logic [REG_W-1:0]    id_reg2,
    input  logic [RADDR_W-1:0]  id_wd,
    input  logic                id_wreg,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [REG_W-1:0]    ex_reg1,
    output logic [REG_W-1:0]    ex_reg2,
    output logic [RADDR_W-1:0]  ex_wd,
    output logic                ex_wreg,
    output logic [CNT_W-1:0]    bubble_cnt
);

    logic                accept;
    logic                issue;
    logic                main_valid;
    logic                main_wreg;
    slot_act_e           main_act;
    logic [ALUOP_W-1:0]  ld_aluop;
    logic [ALUSEL_W-1:0] ld_alusel;
    logic [REG_W-1:0]    ld_reg1;
    logic [REG_W-1:0]    ld_reg2;
    logic [RADDR_W-1:0]  ld_wd;
    logic                ld_wreg;

    assign accept   = id_valid & id_ready;
    assign issue    = main_valid & ex_ready;
    assign ex_valid = main_valid;
    assign ex_wreg  = main_valid & main_wreg;

`ifdef IDEX_SKID_EN
    logic                skid_valid;
    logic                skid_nxt;
    logic                from_skid;
    logic                ready_q;
    slot_act_e           skid_act;
    logic [ALUOP_W-1:0]  sk_aluop;
    logic [ALUSEL_W-1:0] sk_alusel;
    logic [REG_W-1:0]    sk_reg1;
    logic [REG_W-1:0]    sk_reg2;
    logic [RADDR_W-1:0]  sk_wd;
    logic                sk_wreg;

    // The skid only fills while main is stalled; it drains into main on issue.
    always_comb begin
        main_act  = SLOT_HOLD;
        skid_act  = SLOT_HOLD;
        from_skid = 1'b0;
        priority case (1'b1)
            flush: begin
                main_act = SLOT_CLEAR;
                skid_act = SLOT_CLEAR;
            end
            !main_valid: begin
                if (accept) main_act = SLOT_LOAD;
            end
            ex_ready: begin
                if (skid_valid) begin
                    main_act  = SLOT_LOAD;
                    from_skid = 1'b1;
                    skid_act  = SLOT_CLEAR;
                end else if (accept) begin
                    main_act = SLOT_LOAD;
                end else begin
                    main_act = SLOT_CLEAR;
                end
            end
            default: begin
                if (accept) skid_act = SLOT_LOAD;
            end
        endcase
    end

    assign skid_nxt = !flush &
                      ((skid_valid & !issue) |
                       (accept & main_valid & !ex_ready));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_q <= 1'b1;
        else      ready_q <= !skid_nxt;
    end

    assign id_ready  = ready_q;
    assign ld_aluop  = from_skid ? sk_aluop  : id_aluop;
    assign ld_alusel = from_skid ? sk_alusel : id_alusel;
    assign ld_reg1   = from_skid ? sk_reg1   : id_reg1;
    assign ld_reg2   = from_skid ? sk_reg2   : id_reg2;
    assign ld_wd     = from_skid ? sk_wd     : id_wd;
    assign ld_wreg   = from_skid ? sk_wreg   : id_wreg;

    id_ex_payload_slot #(
        .ALUOP_W  (ALUOP_W),
        .ALUSEL_W (ALUSEL_W),
        .REG_W    (REG_W),
        .RADDR_W  (RADDR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .act        (skid_act),
        .new_aluop  (id_aluop),
        .new_alusel (id_alusel),
        .new_reg1   (id_reg1),
        .new_reg2   (id_reg2),
        .new_wd     (id_wd),
        .new_wreg   (id_wreg),
        .valid      (skid_valid),
        .aluop      (sk_aluop),
        .alusel     (sk_alusel),
        .reg1       (sk_reg1),
        .reg2       (sk_reg2),
        .wd         (sk_wd),
        .wreg       (sk_wreg)
    );
`else
    always_comb begin
        main_act = SLOT_HOLD;
        priority case (1'b1)
            flush:   main_act = SLOT_CLEAR;
            accept:  main_act = SLOT_LOAD;
            issue:   main_act = SLOT_CLEAR;
            default: main_act = SLOT_HOLD;
        endcase
    end

    assign id_ready  = !main_valid | ex_ready;
    assign ld_aluop  = id_aluop;
    assign ld_alusel = id_alusel;
    assign ld_reg1   = id_reg1;
    assign ld_reg2   = id_reg2;
    assign ld_wd     = id_wd;
    assign ld_wreg   = id_wreg;
`endif

    id_ex_payload_slot #(
        .ALUOP_W  (ALUOP_W),
        .ALUSEL_W (ALUSEL_W),
        .REG_W    (REG_W),
        .RADDR_W  (RADDR_W)
    ) u_main (
        .clk        (clk),
        .rst        (rst),
        .act        (main_act),
        .new_aluop  (ld_aluop),
        .new_alusel (ld_alusel),
        .new_reg1   (ld_reg1),
        .new_reg2   (ld_reg2),
        .new_wd     (ld_wd),
        .new_wreg   (ld_wreg),
        .valid      (main_valid),
        .aluop      (ex_aluop),
        .alusel     (ex_alusel),
        .reg1       (ex_reg1),
        .reg2       (ex_reg2),
        .wd         (ex_wd),
        .wreg       (main_wreg)
    );

    // Counts idle EX cycles; sticks at all-ones until the next reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (ex_ready && !main_valid &&
                     bubble_cnt != {CNT_W{1'b1}}) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: queue model of held instructions,
// directed scenarios plus randomized traffic (IDEX_SKID_EN aware).
module tb_id_ex_stage_reg;

    localparam int CW = 4;
`ifdef IDEX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
    } ins_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          id_valid = 1'b0;
    logic          id_ready;
    logic [7:0]    id_aluop = '0;
    logic [2:0]    id_alusel = '0;
    logic [31:0]   id_reg1 = '0;
    logic [31:0]   id_reg2 = '0;
    logic [4:0]    id_wd = '0;
    logic          id_wreg = 1'b0;
    logic          ex_valid;
    logic          ex_ready = 1'b0;
    logic [7:0]    ex_aluop;
    logic [2:0]    ex_alusel;
    logic [31:0]   ex_reg1;
    logic [31:0]   ex_reg2;
    logic [4:0]    ex_wd;
    logic          ex_wreg;
    logic [CW-1:0] bubble_cnt;

    ins_t q[$];
    int   m_bub = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_aluop   (id_aluop),
        .id_alusel  (id_alusel),
        .id_reg1    (id_reg1),
        .id_reg2    (id_reg2),
        .id_wd      (id_wd),
        .id_wreg    (id_wreg),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_aluop   (ex_aluop),
        .ex_alusel  (ex_alusel),
        .ex_reg1    (ex_reg1),
        .ex_reg2    (ex_reg2),
        .ex_wd      (ex_wd),
        .ex_wreg    (ex_wreg),
        .bubble_cnt (bubble_cnt)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: ID may hand over one more while the stage holds < capacity.
    function automatic bit m_ready();
        if (SKID) return q.size() < 2;
        return q.size() == 0 || ex_ready;
    endfunction

    function automatic ins_t cur_ins();
        ins_t t;
        t.aluop  = id_aluop;
        t.alusel = id_alusel;
        t.reg1   = id_reg1;
        t.reg2   = id_reg2;
        t.wd     = id_wd;
        t.wreg   = id_wreg;
        return t;
    endfunction

    function automatic ins_t mk(logic [31:0] r1, logic [4:0] wd, logic wr);
        ins_t t;
        t.aluop  = r1[7:0] ^ 8'h5A;
        t.alusel = r1[2:0];
        t.reg1   = r1;
        t.reg2   = ~r1;
        t.wd     = wd;
        t.wreg   = wr;
        return t;
    endfunction

    task automatic drive(bit v, ins_t t, bit rdy, bit fl);
        id_valid  = v;
        id_aluop  = t.aluop;
        id_alusel = t.alusel;
        id_reg1   = t.reg1;
        id_reg2   = t.reg2;
        id_wd     = t.wd;
        id_wreg   = t.wreg;
        ex_ready  = rdy;
        flush     = fl;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick(output bit acc);
        bit rdy_now;
        @(posedge clk);
        acc = 1'b0;
        if (!rst) begin
            q.delete();
            m_bub = 0;
        end else begin
            if (ex_ready && q.size() == 0 && m_bub < (1 << CW) - 1) m_bub++;
            rdy_now = m_ready();
            acc = id_valid && rdy_now;
            if (flush) begin
                q.delete();
            end else begin
                if (ex_ready && q.size() > 0) void'(q.pop_front());
                if (acc) q.push_back(cur_ins());
            end
        end
        #2;
    endtask

    always @(negedge clk) begin
        ins_t h;
        bit v;
        if (chk_en && rst) begin
            v = q.size() > 0;
            h = mk(32'h0, 5'h0, 1'b0);
            h.aluop  = 8'h00;
            h.alusel = 3'h0;
            h.reg2   = 32'h0;
            if (v) h = q[0];
            chk("ex_valid", 64'(ex_valid), 64'(v));
            chk("ex_aluop", 64'(ex_aluop), 64'(h.aluop));
            chk("ex_alusel", 64'(ex_alusel), 64'(h.alusel));
            chk("ex_reg1", 64'(ex_reg1), 64'(h.reg1));
            chk("ex_reg2", 64'(ex_reg2), 64'(h.reg2));
            chk("ex_wd", 64'(ex_wd), 64'(h.wd));
            chk("ex_wreg", 64'(ex_wreg), 64'(v && h.wreg));
            chk("id_ready", 64'(id_ready), 64'(m_ready()));
            chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   a;
        bit   pend;
        ins_t t;
        chk_en = 1'b1;
        drive(1'b0, mk(32'h0, 5'h0, 1'b0), 1'b0, 1'b0);
        tick(a);
        tick(a);
        rst = 1'b1;

        // Streaming, 4 back-to-back
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, mk(32'(i), 5'd3, 1'b1), 1'b1, 1'b0);
            tick(a);
            chk("stream_reg1", 64'(ex_reg1), 64'(i));
            chk("stream_wd", 64'(ex_wd), 64'd3);
        end
        chk("stream_nobubble", 64'(bubble_cnt), 64'd1);

        // Stall with ID holding a second instruction
        drive(1'b1, mk(32'hA5A5_0001, 5'd4, 1'b1), 1'b1, 1'b0);
        tick(a);
        drive(1'b1, mk(32'hA5A5_0002, 5'd4, 1'b1), 1'b0, 1'b0);
        #1;
        chk("stall_id_ready", 64'(id_ready), 64'(SKID));
        pend = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(pend, mk(32'hA5A5_0002, 5'd4, 1'b1), 1'b0, 1'b0);
            tick(a);
            if (a) pend = 1'b0;
            chk("stall_hold", 64'(ex_reg1), 64'hA5A5_0001);
        end
        drive(pend, mk(32'hA5A5_0002, 5'd4, 1'b1), 1'b0, 1'b0);
        #1;
        chk("stall_full", 64'(id_ready), 64'd0);
        drive(pend, mk(32'hA5A5_0002, 5'd4, 1'b1), 1'b1, 1'b0);
        tick(a);
        chk("release_reg1", 64'(ex_reg1), 64'hA5A5_0002);
        drive(1'b0, mk(32'h0, 5'd0, 1'b0), 1'b1, 1'b0);
        tick(a);
        chk("release_empty", 64'(ex_valid), 64'd0);

        // Flush with held instructions and an incoming one
        drive(1'b1, mk(32'h100, 5'd9, 1'b1), 1'b0, 1'b0);
        tick(a);
        drive(1'b1, mk(32'h101, 5'd9, 1'b1), 1'b0, 1'b0);
        tick(a);
        drive(1'b1, mk(32'h102, 5'd9, 1'b1), 1'b0, 1'b1);
        tick(a);
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_wreg", 64'(ex_wreg), 64'd0);
        chk("flush_reg1", 64'(ex_reg1), 64'd0);
        drive(1'b1, mk(32'h103, 5'd9, 1'b1), 1'b1, 1'b0);
        tick(a);
        chk("after_flush", 64'(ex_reg1), 64'h103);
        drive(1'b0, mk(32'h0, 5'd0, 1'b0), 1'b1, 1'b0);
        tick(a);
        chk("flush_skid_gone", 64'(ex_valid), 64'd0);

        // Write-enable gating once the slot empties
        drive(1'b1, mk(32'h55, 5'd7, 1'b1), 1'b1, 1'b0);
        tick(a);
        chk("gate_wreg_on", 64'(ex_wreg), 64'd1);
        chk("gate_wd", 64'(ex_wd), 64'd7);
        drive(1'b0, mk(32'h0, 5'd0, 1'b0), 1'b1, 1'b0);
        tick(a);
        chk("gate_wreg_off", 64'(ex_wreg), 64'd0);
        chk("gate_wd_nop", 64'(ex_wd), 64'd0);

        // Asynchronous reset mid-transfer
        drive(1'b1, mk(32'h77, 5'd2, 1'b1), 1'b0, 1'b0);
        tick(a);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(ex_valid), 64'd0);
        chk("rst_reg1", 64'(ex_reg1), 64'd0);
        chk("rst_aluop", 64'(ex_aluop), 64'd0);
        chk("rst_wreg", 64'(ex_wreg), 64'd0);
        chk("rst_bubble", 64'(bubble_cnt), 64'd0);
        drive(1'b0, mk(32'h0, 5'd0, 1'b0), 1'b1, 1'b0);
        tick(a);
        rst = 1'b1;

        // Bubble counting and saturation
        repeat (10) tick(a);
        chk("bubble_10", 64'(bubble_cnt), 64'd10);
        repeat (20) tick(a);
        chk("bubble_sat", 64'(bubble_cnt), 64'hF);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            t.aluop  = 8'($urandom);
            t.alusel = 3'($urandom);
            t.reg1   = $urandom;
            t.reg2   = $urandom;
            t.wd     = 5'($urandom);
            t.wreg   = 1'($urandom);
            drive(($urandom % 4) != 0, t, ($urandom % 3) != 0, ($urandom % 32) == 0);
            if (i == 1500) rst = 1'b0;
            tick(a);
            rst = 1'b1;
        end

        drive(1'b0, mk(32'h0, 5'd0, 1'b0), 1'b0, 1'b0);
        tick(a);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
